// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state enum, width helpers and a reference pick function.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // Keeps counter and index widths at least one bit for the degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Behavioural equivalent of rr_arb_pick: first unmasked request at or after ptr.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input logic [MAX_REQ-1:0]   mask,
                                    input int unsigned          n);
    pick_t r;
    r = '0;
    for (int k = int'(n) - 1; k >= 0; k--) begin
      int unsigned j;
      j = (int'(ptr) + k) % n;
      if (req[j] && !mask[j]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: rotate the masked requests down by ptr,
// take the lowest set bit, then rotate the offset back to an absolute index.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] doubled;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  always_comb begin
    masked  = req_i & ~mask_i;
    doubled = {masked, masked};
    shifted = doubled >> ptr_i;
    rotated = shifted[N_REQ-1:0];
    found_o = |rotated;
    offset  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = IDX_W'(k);
      end
    end
    // Undo the rotation modulo N_REQ; ptr and offset are both below N_REQ.
    sum = {1'b0, ptr_i} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(N_REQ)) begin
      sum = sum - (IDX_W+1)'(N_REQ);
    end
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with owner hold and forced rotation after MAX_HOLD cycles.
// Define RR_GRANT_ARBITER_ASSERT_EN to compile the embedded req/gnt contract assertions.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     preempt
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = idx_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic              preempt_q, preempt_d;

  logic [IDX_W-1:0]  ownerNext;
  logic [IDX_W-1:0]  pickPtr;
  logic [N_REQ-1:0]  pickMask;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickFound;
  logic              ownerReq;
  logic              otherReq;

  // While owned, both release and preemption search from the slot after the owner,
  // never picking the owner itself.
  always_comb begin
    ownerNext = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    pickPtr   = (state_q == OWNED) ? ownerNext : ptr_q;
    pickMask  = (state_q == OWNED) ? gnt_q : '0;
    ownerReq  = |(req & gnt_q);
    otherReq  = |(req & ~gnt_q);
  end

  rr_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (pickPtr),
    .mask_i  (pickMask),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d   = OWNED;
          gnt_d     = ONE_HOT0 << pickIdx;
          idx_d     = pickIdx;
          holdCnt_d = '0;
        end else begin
          gnt_d = '0;
          idx_d = '0;
        end
      end
      OWNED: begin
        if (!ownerReq) begin
          ptr_d     = ownerNext;
          holdCnt_d = '0;
          if (pickFound) begin
            gnt_d = ONE_HOT0 << pickIdx;
            idx_d = pickIdx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else if (otherReq && holdCnt_q == HOLD_LAST) begin
          ptr_d     = ownerNext;
          gnt_d     = ONE_HOT0 << pickIdx;
          idx_d     = pickIdx;
          holdCnt_d = '0;
          preempt_d = 1'b1;
        end else if (holdCnt_q != HOLD_LAST) begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign preempt   = preempt_q;

`ifdef RR_GRANT_ARBITER_ASSERT_EN
  localparam int unsigned WAIT_MAX = (N_REQ - 1) * MAX_HOLD + 1;

  aGntOnehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("[ASSERT] gnt not onehot0 at %0t idx %0d", $time, gnt_idx);

  aGntIdx: assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> gnt == (ONE_HOT0 << gnt_idx))
    else $error("[ASSERT] gnt/gnt_idx disagree at %0t idx %0d", $time, gnt_idx);

  aPreemptValid: assert property (@(posedge clk) disable iff (rst) preempt |-> gnt_valid)
    else $error("[ASSERT] preempt without grant at %0t idx %0d", $time, gnt_idx);

  for (genvar i = 0; i < N_REQ; i++) begin : g_req_props
    aGntHadReq: assert property (@(posedge clk) disable iff (rst) gnt[i] |-> $past(req[i]))
      else $error("[ASSERT] grant without request at %0t idx %0d", $time, i);

    aFairWait: assert property (@(posedge clk) disable iff (rst)
      req[i] && !gnt[i] |-> ##[1:WAIT_MAX] gnt[i])
      else $error("[ASSERT] wait bound exceeded at %0t idx %0d", $time, i);
  end
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N_REQ=4, MAX_HOLD=8) plus a random
// phase that holds pending requests until granted and tracks invariants.
module tb_rr_grant_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = (N_REQ - 1) * MAX_HOLD + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       preempt;

  int checksRun    = 0;
  int checksPassed = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .preempt   (preempt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksRun++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, clock one edge, and settle so outputs are sampled off the edge.
  task automatic applyStimulus(input logic rstVal, input logic [3:0] reqVal);
    rst = rstVal;
    req = reqVal;
    @(posedge clk);
    #1;
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] expGnt,
                            input logic [1:0] expIdx, input logic expPreempt);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, "_idx"}, 32'(gnt_idx), 32'(expIdx));
    checkOutput({tag, "_valid"}, 32'(gnt_valid), 32'(|expGnt));
    checkOutput({tag, "_preempt"}, 32'(preempt), 32'(expPreempt));
  endtask

  logic [3:0] nextReq;
  int         waitCnt [4];
  int         maxWait;
  int         badOnehot, badNoReq, badIdx, badPreempt, grantCycles;

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // T1: reset holds everything low even with all requests up
    applyStimulus(1'b1, 4'b1111);
    checkGrant("t1_rst_edge1", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b1, 4'b1111);
    checkGrant("t1_rst_edge2", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b1111);
    checkGrant("t1_first_gnt", 4'b0001, 2'd0, 1'b0);

    // T2: each owner releases right after its grant; rotation with wrap, no bubble
    applyStimulus(1'b0, 4'b1110);
    checkGrant("t2_rot1", 4'b0010, 2'd1, 1'b0);
    applyStimulus(1'b0, 4'b1101);
    checkGrant("t2_rot2", 4'b0100, 2'd2, 1'b0);
    applyStimulus(1'b0, 4'b1011);
    checkGrant("t2_rot3", 4'b1000, 2'd3, 1'b0);
    applyStimulus(1'b0, 4'b0111);
    checkGrant("t2_wrap", 4'b0001, 2'd0, 1'b0);

    // T3: req[0] held, req[2] joins at cycle 3; rotation forced after 8 grant cycles
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    checkGrant("t3_hold_c0", 4'b0001, 2'd0, 1'b0);
    for (int c = 1; c < MAX_HOLD; c++) begin
      applyStimulus(1'b0, (c >= 3) ? 4'b0101 : 4'b0001);
      checkGrant($sformatf("t3_hold_c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0101);
    checkGrant("t3_preempt", 4'b0100, 2'd2, 1'b1);
    applyStimulus(1'b0, 4'b0101);
    checkGrant("t3_after_preempt", 4'b0100, 2'd2, 1'b0);

    // T4: lone owner keeps the grant; saturated counter preempts on first waiter
    applyStimulus(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 4'b0010);
      checkGrant($sformatf("t4_lone_c%0d", c), 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(1'b0, 4'b1010);
    checkGrant("t4_waiter", 4'b1000, 2'd3, 1'b1);

    // T5: owner releases on the hold-limit cycle; release wins, no preempt
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    checkGrant("t5_start", 4'b0001, 2'd0, 1'b0);
    for (int c = 1; c < MAX_HOLD; c++) begin
      applyStimulus(1'b0, 4'b0101);
    end
    checkGrant("t5_at_limit", 4'b0001, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b0100);
    checkGrant("t5_release", 4'b0100, 2'd2, 1'b0);

    // T6: reset mid-grant drops gnt immediately and returns ptr to 0
    applyStimulus(1'b1, 4'b0100);
    checkGrant("t6_rst", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b1111);
    checkGrant("t6_after_rst", 4'b0001, 2'd0, 1'b0);

    // Random phase: pending requests stay up until granted, owners drop at random
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    maxWait     = 0;
    badOnehot   = 0;
    badNoReq    = 0;
    badIdx      = 0;
    badPreempt  = 0;
    grantCycles = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nextReq = req;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(3) == 0) nextReq[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) nextReq[i] = 1'b1;
        end
      end
      applyStimulus(1'b0, nextReq);
      if (!$onehot0(gnt)) badOnehot++;
      if ((gnt & ~nextReq) != 4'b0000) badNoReq++;
      if ((gnt_valid != |gnt) || (gnt_valid && gnt != (4'b0001 << gnt_idx)) ||
          (!gnt_valid && gnt_idx != 2'd0)) badIdx++;
      if (preempt && !gnt_valid) badPreempt++;
      if (gnt_valid) grantCycles++;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          waitCnt[i] = 0;
        end else if (nextReq[i]) begin
          waitCnt[i]++;
          if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
        end else begin
          waitCnt[i] = 0;
        end
      end
    end
    checkOutput("rand_onehot_violations", 32'(badOnehot), 32'd0);
    checkOutput("rand_gnt_without_req", 32'(badNoReq), 32'd0);
    checkOutput("rand_idx_violations", 32'(badIdx), 32'd0);
    checkOutput("rand_preempt_without_gnt", 32'(badPreempt), 32'd0);
    checkOutput("rand_wait_within_bound", 32'(maxWait <= WAIT_MAX), 32'd1);
    checkOutput("rand_grants_seen", 32'(grantCycles > 1000), 32'd1);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
